pipe_barrel_shifter: RTL
========================

# pipe_barrel_shifter

Parametrised, pipelined barrel shifter for the execute stage of the pipelined RISC CPU. It is the successor to the single-cycle combinational shifter.
- Supports configurable data width.
- Supports five shift/rotate modes plus pass-through.
- Uses one pipeline stage per shift-amount bit.
- Uses a valid/ready handshake with back-pressure and carries a sideband tag (e.g. destination register) alongside each result.

## Interface
- `WIDTH`, 32: data width; power of two, ≥ 8.
- `TAGW`, 5: sideband tag width.
- `LOG2W`, `$clog2(WIDTH)`: derived; do not override.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input operation present.
- `in_ready`  out  1  pipeline accepts input this cycle.
- `in_data`  in  WIDTH  operand A.
- `in_amt`  in  LOG2W+1  shift amount, unsigned (0..2·WIDTH−1).
- `in_op`  in  3  mode: 0 SLL, 1 SRL, 2 SRA, 3 ROL, 4 ROR, 5–7 pass-through.
- `in_tag`  in  TAGW  sideband, returned unchanged with result.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts result.
- `out_data`  out  WIDTH  result.
- `out_tag`  out  TAGW  tag of this result.
- `out_carry`  out  1  last bit shifted out; present only with `SHIFTER_CARRY_EN`.

## Operation
- **Transfer rule:** a transfer occurs on a cycle with `in_valid && in_ready`. An output transfer occurs on a cycle with `out_valid && out_ready`.
- **Global advance enable:** `adv = !out_valid || out_ready`. `in_ready = adv`, combinationally.
- **Stall behaviour:** when `adv` is 0, every stage holds, bubbles included. When `adv` is 1, every stage shifts forward one position.
- **Stage 0 (pre-fill):** registers data, op, tag and the effective amount.
  - Rotates: effective amount = `in_amt mod WIDTH`.
  - SLL/SRL with `in_amt ≥ WIDTH`: data is forced to 0 and the effective amount to 0.
  - SRA with `in_amt ≥ WIDTH`: data is forced to all copies of `in_data[WIDTH-1]` and the effective amount to 0.
  - Pass-through ops: effective amount = 0.
- **Stages 1..LOG2W:** stage k conditionally shifts or rotates by `2^(k-1)` when effective-amount bit k−1 is set.
  - SLL: zero-fill on the right.
  - SRL: zero-fill on the left.
  - SRA: sign-fill from the original MSB, carried in a per-stage register.
  - ROL/ROR: wrap-around.
- **Output:** the last stage's registers drive `out_*` directly. There is no combinational path from `in_*` to `out_*`.
- **Result ordering:** results emerge in acceptance order. No reordering and no drops.
- **Reset:**
  - All stage valid bits are 0.
  - `out_valid`, `out_data`, `out_tag` and `out_carry` are 0.
  - `in_ready` is 1 in the cycle after reset deasserts.
  - Reset asserted mid-operation discards all in-flight operations in the same edge.
- **Boundary conditions:**
  - Amount 0 in any mode: `out_data == in_data`.
  - Amount `WIDTH` with ROL/ROR: identity.
  - Amount `2·WIDTH−1` with ROL: same result as ROL by `WIDTH−1`.
  - `in_valid` with `in_ready` = 0: nothing is accepted. The source must hold its inputs.

## Timing
- **Latency:** LOG2W+1 cycles from the accept edge to `out_valid` when unstalled. For WIDTH=32 this is 6 cycles.
- **Throughput:** one operation per cycle while `out_ready` = 1.
- **Back-pressure:** with `out_ready` held 0, `out_valid`, `out_data` and `out_tag` are stable until the transfer.
- **Stalled input:** `in_ready` drops in the same cycle that `out_valid && !out_ready` holds.
- **Pipeline occupancy:** up to LOG2W+1 operations are in flight. No skid buffer is used.

## Configuration
- **`SHIFTER_CARRY_EN` defined:**
  - Adds the `out_carry` port and per-stage carry registers.
  - SLL/ROL: carry = `A[WIDTH-amt]`.
  - SRL/SRA/ROR: carry = `A[amt-1]`, where `amt` is the effective amount after stage 0.
  - Carry = 0 when the effective amount is 0, except for over-range (`in_amt ≥ WIDTH`) shifts:
    - SLL with `in_amt == WIDTH`: carry = `A[0]`.
    - SRL with `in_amt == WIDTH`: carry = `A[WIDTH-1]`.
    - SLL/SRL with `in_amt > WIDTH`: carry = 0.
    - SRA with `in_amt ≥ WIDTH`: carry = `A[WIDTH-1]`.
  - Pass-through: carry = 0.
- **`SHIFTER_CARRY_EN` undefined:** the port and carry logic are absent. Data and timing are identical.

## Test plan
All scenarios use WIDTH=32 with `out_ready` = 1 unless stated.
- **Reset:** assert `rst` 3 cycles, then release. `out_valid` = 0 and `out_data` = 0 during reset. `in_ready` = 1 the cycle after release.
- **Per-mode single operation:** A=0x8000_00F1, amt=4, tag=7.
  - Expected results after exactly 6 cycles:
    - SLL → 0x0000_0F10
    - SRL → 0x0800_000F
    - SRA → 0xF800_000F
    - ROL → 0x0000_0F18
    - ROR → 0x1800_000F
  - `out_tag` = 7 in every case.
  - With carry enabled, carry = 0,0,0,0,0 respectively.
- **Over-range amounts:**
  - SRA A=0x8000_0000, amt=40 → 0xFFFF_FFFF.
  - SRL A=0xFFFF_FFFF, amt=32 → 0; carry = 1 when enabled.
  - ROR A=0x1234_5678, amt=32 → 0x1234_5678.
- **Back-to-back with stall:** issue 8 consecutive SLL ops, A=1, amt=0..7. Hold `out_ready` = 0 for cycles 7–10, then release.
  - Results are 1,2,4,…,128 in order, none lost or duplicated.
  - `out_data` is stable while stalled.
  - `in_ready` = 0 during the stall.
- **Reset mid-flight:** accept 3 ops, then assert `rst` for 1 cycle. No `out_valid` appears afterwards, and the next accepted op is returned after 6 cycles.

Source files
------------

// File: rtl/pipe_barrel_shifter.sv
// Pipelined barrel shifter: stage 0 normalises the amount, then one stage per amount bit.
// Optional carry-out of the last shifted bit is built when SHIFTER_CARRY_EN is defined.
module pipe_barrel_shifter #(
  parameter int WIDTH = 32,
  parameter int TAGW  = 5,
  parameter int LOG2W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LOG2W:0]   in_amt,
  input  logic [2:0]       in_op,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAGW-1:0]  out_tag
`ifdef SHIFTER_CARRY_EN
  ,
  output logic             out_carry
`endif
);

  localparam int NS = LOG2W + 1;

  localparam logic [2:0] OP_SLL = 3'd0;
  localparam logic [2:0] OP_SRL = 3'd1;
  localparam logic [2:0] OP_SRA = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;

  typedef struct packed {
    logic             valid;
    logic [2:0]       op;
    logic [LOG2W-1:0] amt;
    logic             sign;
`ifdef SHIFTER_CARRY_EN
    logic             carry;
`endif
    logic [TAGW-1:0]  tag;
    logic [WIDTH-1:0] data;
  } stage_t;

  stage_t st [NS];
  stage_t pre;
  logic   adv;
  logic   over;

  // Handshake: input transfers on in_valid && in_ready, output on out_valid && out_ready.
  // The whole pipe advances together (bubbles included) whenever the last stage can move.
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = st[LOG2W].valid;
  assign out_data  = st[LOG2W].data;
  assign out_tag   = st[LOG2W].tag;
`ifdef SHIFTER_CARRY_EN
  assign out_carry = st[LOG2W].carry;
`endif

  assign over = in_amt[LOG2W];

  // Over-range shifts are resolved here so later stages only ever see amounts < WIDTH.
  always_comb begin
    pre       = '0;
    pre.valid = in_valid;
    pre.op    = in_op;
    pre.tag   = in_tag;
    pre.data  = in_data;
    pre.sign  = in_data[WIDTH-1];
    pre.amt   = in_amt[LOG2W-1:0];
    case (in_op)
      OP_SLL, OP_SRL: begin
        if (over) begin
          pre.data = '0;
          pre.amt  = '0;
`ifdef SHIFTER_CARRY_EN
          if (in_amt[LOG2W-1:0] == '0)
            pre.carry = (in_op == OP_SLL) ? in_data[0] : in_data[WIDTH-1];
`endif
        end
      end
      OP_SRA: begin
        if (over) begin
          pre.data = {WIDTH{in_data[WIDTH-1]}};
          pre.amt  = '0;
`ifdef SHIFTER_CARRY_EN
          pre.carry = in_data[WIDTH-1];
`endif
        end
      end
      OP_ROL, OP_ROR: ;
      default: pre.amt = '0;
    endcase
  end

  function automatic stage_t step(input stage_t s, input int k);
    stage_t r;
    int     sh;
    logic   en;
    r  = s;
    sh = 1 << k;
    en = |(s.amt & (LOG2W'(1) << k));
    if (en) begin
      case (s.op)
        OP_SLL: begin
          r.data = s.data << sh;
`ifdef SHIFTER_CARRY_EN
          r.carry = s.data[LOG2W'(WIDTH - sh)];
`endif
        end
        OP_SRL: begin
          r.data = s.data >> sh;
`ifdef SHIFTER_CARRY_EN
          r.carry = s.data[LOG2W'(sh - 1)];
`endif
        end
        OP_SRA: begin
          r.data = (s.data >> sh) | (s.sign ? ~({WIDTH{1'b1}} >> sh) : '0);
`ifdef SHIFTER_CARRY_EN
          r.carry = s.data[LOG2W'(sh - 1)];
`endif
        end
        OP_ROL: begin
          r.data = (s.data << sh) | (s.data >> (WIDTH - sh));
`ifdef SHIFTER_CARRY_EN
          r.carry = s.data[LOG2W'(WIDTH - sh)];
`endif
        end
        OP_ROR: begin
          r.data = (s.data >> sh) | (s.data << (WIDTH - sh));
`ifdef SHIFTER_CARRY_EN
          r.carry = s.data[LOG2W'(sh - 1)];
`endif
        end
        default: ;
      endcase
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NS; k++) st[k] <= '0;
    end else if (adv) begin
      st[0] <= pre;
      for (int k = 1; k < NS; k++) st[k] <= step(st[k-1], k - 1);
    end
  end

endmodule
